// File: rtl/adder_rr_arbiter.sv
// Round-robin front end for a shared, fully pipelined adder. Grants one requester per cycle,
// registers its operands toward the adder, and tags each op with its requester ID. The tag is
// walked alongside the adder pipeline so results come back with their owner. Any completion
// that does not line up with a tag raises a sticky error.
module adder_rr_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDER_LAT = 2,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     arb_en,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         add_value_a,
  output logic [WIDTH-1:0]         add_value_b,
  output logic                     add_data_val,
  input  logic [WIDTH-1:0]         add_sum_result,
  input  logic                     add_sum_carry,
  input  logic                     add_data_ready,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic                     busy,
  output logic                     seq_err,
  output logic [CNT_W-1:0]         op_count
);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             grant_vld;
  logic [ID_W-1:0]  grant_id;
  logic [WIDTH-1:0] sel_a, sel_b;

  logic [WIDTH-1:0] value_a_q, value_b_q;
  logic             data_val_q;
  logic [ID_W-1:0]  iss_id_q;

  logic [ADDER_LAT-1:0] tag_vld_q;
  logic [ID_W-1:0]      tag_id_q [ADDER_LAT];

  logic             complete;
  logic             rsp_valid_q, rsp_carry_q, seq_err_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic [CNT_W-1:0] op_count_q;

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin : p_grant
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_id  = '0;
    if (reset_n && arb_en) begin
      for (int j = 0; j < int'(NUM_REQ); j++) begin
        idx = (int'(ptr_q) + j) % int'(NUM_REQ);
        if (!grant_vld && req_valid[idx]) begin
          grant_vld = 1'b1;
          grant_id  = ID_W'(idx);
        end
      end
    end
  end

  assign req_ready = grant_vld ? (NUM_REQ'(1) << grant_id) : '0;
  assign sel_a     = req_a[32'(grant_id) * WIDTH +: WIDTH];
  assign sel_b     = req_b[32'(grant_id) * WIDTH +: WIDTH];

  // Pointer moves just past the winner; holds when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Issue stage: operands and the owner tag launched toward the adder.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      data_val_q <= 1'b0;
      value_a_q  <= '0;
      value_b_q  <= '0;
      iss_id_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      data_val_q <= grant_vld;
      if (grant_vld) begin
        value_a_q <= sel_a;
        value_b_q <= sel_b;
        iss_id_q  <= grant_id;
      end
    end
  end

  // Tag shadow of the adder pipeline; the last stage lines up with add_data_ready.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tag_vld_q <= '0;
      for (int i = 0; i < int'(ADDER_LAT); i++) begin
        tag_id_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0] <= data_val_q;
      tag_id_q[0]  <= iss_id_q;
      for (int i = 1; i < int'(ADDER_LAT); i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  assign complete = add_data_ready & tag_vld_q[ADDER_LAT-1];

  // Response capture, completion count and sticky alignment check.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      op_count_q  <= '0;
      seq_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= complete;
      if (complete) begin
        rsp_id_q    <= tag_id_q[ADDER_LAT-1];
        rsp_sum_q   <= add_sum_result;
        rsp_carry_q <= add_sum_carry;
        op_count_q  <= op_count_q + 1'b1;
      end
      if (add_data_ready != tag_vld_q[ADDER_LAT-1]) begin
        seq_err_q <= 1'b1;
      end
    end
  end

  assign add_value_a  = value_a_q;
  assign add_value_b  = value_b_q;
  assign add_data_val = data_val_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_sum      = rsp_sum_q;
  assign rsp_carry    = rsp_carry_q;
  assign seq_err      = seq_err_q;
  assign op_count     = op_count_q;
  assign busy         = data_val_q | (|tag_vld_q) | rsp_valid_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Bench for adder_rr_arbiter: external 2-stage adder model, transaction-level reference model
// (queue of in-flight ops with due edges), per-cycle compare, plus directed literal checks.
module tb_adder_rr_arbiter;
  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n, arb_en;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   add_value_a, add_value_b, add_sum_result, rsp_sum;
  logic           add_data_val, add_sum_carry, add_data_ready;
  logic           rsp_valid, rsp_carry, busy, seq_err;
  logic [1:0]     rsp_id;
  logic [15:0]    op_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adder_rr_arbiter #(.WIDTH(W), .NUM_REQ(N), .ADDER_LAT(2), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .arb_en(arb_en), .req_valid(req_valid), .req_a(req_a),
    .req_b(req_b), .req_ready(req_ready), .add_value_a(add_value_a),
    .add_value_b(add_value_b), .add_data_val(add_data_val), .add_sum_result(add_sum_result),
    .add_sum_carry(add_sum_carry), .add_data_ready(add_data_ready), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .busy(busy),
    .seq_err(seq_err), .op_count(op_count)
  );

  // External adder: samples on Data_val, result and Data_ready two edges later.
  logic [W:0] ad_s0, ad_s1;
  logic       ad_v0, ad_v1;
  logic       force_rdy;
  always @(posedge clk) begin
    if (!reset_n) begin
      ad_v0 <= 1'b0; ad_v1 <= 1'b0; ad_s0 <= '0; ad_s1 <= '0;
    end else begin
      ad_v0 <= add_data_val;
      ad_s0 <= {1'b0, add_value_a} + {1'b0, add_value_b};
      ad_v1 <= ad_v0;
      ad_s1 <= ad_s0;
    end
  end
  assign add_data_ready = ad_v1 | force_rdy;
  assign add_sum_result = ad_s1[W-1:0];
  assign add_sum_carry  = ad_s1[W];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: an op accepted at edge E responds at edge E+3.
  typedef struct { int unsigned acc; int id; logic [W-1:0] a; logic [W-1:0] b; } op_t;
  typedef struct { int unsigned e; int id; logic [W-1:0] sum; logic c; } ev_t;
  op_t q[$];
  ev_t gnt_log[$], rsp_log[$];
  int unsigned ecnt = 0;
  int unsigned busy_fall = 0;
  bit          prev_busy = 1'b0;
  bit          m_live = 1'b0;
  int          m_ptr = 0, m_id = 0;
  bit          m_val, m_rsp_valid, m_carry, m_err, m_busy;
  logic [W-1:0] m_a, m_b, m_sum;
  logic [15:0] m_cnt;

  // Compare outputs against the model, log observations, then predict the coming edge.
  always @(negedge clk) begin : model
    int gi;
    int idx;
    bit due;
    op_t o;
    logic [W:0] s;
    logic [N-1:0] exp_rdy;
    if (m_live) begin
      chk("add_data_val", add_data_val, m_val);
      chk("add_value_a", add_value_a, m_a);
      chk("add_value_b", add_value_b, m_b);
      chk("rsp_valid", rsp_valid, m_rsp_valid);
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_sum", rsp_sum, m_sum);
      chk("rsp_carry", rsp_carry, m_carry);
      chk("seq_err", seq_err, m_err);
      chk("op_count", op_count, m_cnt);
      chk("busy", busy, m_busy);
    end
    gi = -1;
    if (reset_n === 1'b1 && arb_en === 1'b1) begin
      for (int j = 0; j < N; j++) begin
        idx = (m_ptr + j) % N;
        if (gi < 0 && req_valid[idx]) gi = idx;
      end
    end
    exp_rdy = (gi >= 0) ? N'(1 << gi) : '0;
    chk("req_ready", req_ready, exp_rdy);

    for (int i = 0; i < N; i++) begin
      if (req_ready[i] === 1'b1) gnt_log.push_back('{ecnt + 1, i, '0, 1'b0});
    end
    if (rsp_valid === 1'b1) rsp_log.push_back('{ecnt, int'(rsp_id), rsp_sum, rsp_carry});
    if (prev_busy && busy === 1'b0) busy_fall = ecnt;
    prev_busy = (busy === 1'b1);

    if (reset_n !== 1'b1) begin
      q.delete();
      m_ptr = 0; m_val = 0; m_a = '0; m_b = '0; m_rsp_valid = 0; m_id = 0;
      m_sum = '0; m_carry = 0; m_err = 0; m_cnt = '0; m_live = 1'b1;
    end else begin
      due = (q.size() > 0) && (q[0].acc + 3 == ecnt + 1);
      m_rsp_valid = 1'b0;
      if (add_data_ready !== due) m_err = 1'b1;
      if (due) begin
        o = q.pop_front();
        if (add_data_ready === 1'b1) begin
          s = {1'b0, o.a} + {1'b0, o.b};
          m_rsp_valid = 1'b1;
          m_id = o.id;
          m_sum = s[W-1:0];
          m_carry = s[W];
          m_cnt = m_cnt + 16'd1;
        end
      end
      if (gi >= 0) begin
        m_val = 1'b1;
        m_a = req_a[gi*W +: W];
        m_b = req_b[gi*W +: W];
        q.push_back('{ecnt + 1, gi, m_a, m_b});
        m_ptr = (gi + 1) % N;
      end else begin
        m_val = 1'b0;
      end
    end
    m_busy = (q.size() > 0) || m_rsp_valid;
    ecnt++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i] = 1'b1;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
  endtask

  task automatic run_one(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    set_req(i, a, b);
    step();
    req_valid = '0;
    repeat (4) step();
  endtask

  int exp_ord[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    reset_n = 1'b0; arb_en = 1'b1; req_valid = '0; req_a = '0; req_b = '0; force_rdy = 1'b0;
    step();
    do_reset();

    // Single op on requester 2.
    gnt_log.delete(); rsp_log.delete();
    set_req(2, 8'h3C, 8'h55);
    at_neg();
    chk("single_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    at_neg();
    chk("single_data_val", add_data_val, 1'b1);
    repeat (4) step();
    chk("single_rsp_count", rsp_log.size(), 1);
    if (rsp_log.size() == 1 && gnt_log.size() == 1) begin
      chk("single_latency", rsp_log[0].e - gnt_log[0].e, 3);
      chk("single_id", rsp_log[0].id, 2);
      chk("single_sum", rsp_log[0].sum, 8'h91);
      chk("single_carry", rsp_log[0].c, 1'b0);
    end
    chk("single_op_count", op_count, 1);

    // Carry-out cases.
    run_one(0, 8'hFF, 8'h01);
    chk("ovf1_sum", rsp_sum, 8'h00);
    chk("ovf1_carry", rsp_carry, 1'b1);
    chk("ovf1_id", rsp_id, 0);
    run_one(0, 8'h80, 8'h80);
    chk("ovf2_sum", rsp_sum, 8'h00);
    chk("ovf2_carry", rsp_carry, 1'b1);

    // Fairness: all requesters held for 8 grants from pointer 0.
    do_reset();
    gnt_log.delete(); rsp_log.delete();
    for (int i = 0; i < N; i++) set_req(i, 8'(16 * i + 1), 8'(3 * i + 7));
    repeat (8) step();
    req_valid = '0;
    repeat (5) step();
    chk("fair_gnt_count", gnt_log.size(), 8);
    chk("fair_rsp_count", rsp_log.size(), 8);
    if (gnt_log.size() == 8 && rsp_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("fair_gnt_order", gnt_log[i].id, exp_ord[i]);
        chk("fair_rsp_order", rsp_log[i].id, exp_ord[i]);
        chk("fair_back_to_back", rsp_log[i].e, rsp_log[0].e + i);
      end
    end
    chk("fair_op_count", op_count, 8);

    // Pointer continuity: after granting 1, requesters 3 and 0 compete.
    run_one(1, 8'h11, 8'h22);
    gnt_log.delete();
    set_req(0, 8'h01, 8'h02);
    set_req(3, 8'h03, 8'h04);
    step();
    step();
    req_valid = '0;
    at_neg();
    chk("cont_count", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      chk("cont_first", gnt_log[0].id, 3);
      chk("cont_second", gnt_log[1].id, 0);
    end
    repeat (5) step();

    // Drain: three ops in flight, then grants disabled.
    rsp_log.delete();
    for (int i = 0; i < N; i++) set_req(i, 8'(i + 40), 8'(i + 90));
    repeat (3) step();
    arb_en = 1'b0;
    at_neg();
    chk("drain_no_ready", req_ready, 4'b0000);
    repeat (6) step();
    req_valid = '0;
    arb_en = 1'b1;
    chk("drain_rsp_count", rsp_log.size(), 3);
    if (rsp_log.size() == 3) chk("drain_busy_fall", busy_fall, rsp_log[2].e + 1);

    // Spurious completion with an empty pipeline.
    rsp_log.delete();
    force_rdy = 1'b1;
    step();
    force_rdy = 1'b0;
    at_neg();
    chk("err_set", seq_err, 1'b1);
    chk("err_no_rsp", rsp_valid, 1'b0);
    repeat (3) step();
    at_neg();
    chk("err_sticky", seq_err, 1'b1);
    chk("err_rsp_count", rsp_log.size(), 0);

    // Reset with two ops in flight.
    step();
    rsp_log.delete();
    set_req(0, 8'h12, 8'h34);
    step();
    req_valid = '0;
    set_req(1, 8'h56, 8'h78);
    step();
    req_valid = '0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    at_neg();
    chk("rst_seq_err", seq_err, 1'b0);
    chk("rst_op_count", op_count, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data_val", add_data_val, 1'b0);
    chk("rst_value_a", add_value_a, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_id", rsp_id, 0);
    repeat (5) step();
    chk("rst_no_rsp", rsp_log.size(), 0);

    // Random traffic, including withdrawals and enable toggling.
    for (int c = 0; c < 600; c++) begin
      req_valid = N'($urandom);
      req_a = $urandom;
      req_b = $urandom;
      arb_en = ($urandom_range(7) != 0);
      step();
    end
    req_valid = '0;
    arb_en = 1'b1;
    repeat (6) step();
    at_neg();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one pipelined WIDTH-bit adder datapath between NUM_REQ requesters using round-robin arbitration.
- Sits between requester-side valid/ready ports and the adder's Value_a/Value_b/Data_val inputs and Sum_result/Sum_carry/Data_ready outputs.
- Tags every issued operation with the requester ID and returns each result with that ID.
- Checks that adder completions match the expected issue pipeline, and flags a sticky error on any mismatch.

Parameters:
- WIDTH, 8, operand and sum width; must match the adder instance.
- NUM_REQ, 4, number of requesters, 2..8.
- ADDER_LAT, 2, cycles from adder input sample edge (Data_val high) to Data_ready high.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock for the arbiter and the adder.
- reset_n  in  1  synchronous, active-low reset.
- arb_en  in  1  1 = grants allowed; 0 = no new grants, in-flight ops drain.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_a  in  NUM_REQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B, same slicing.
- req_ready  out  NUM_REQ  one-hot or zero; transfer on req_valid[i] & req_ready[i].
- add_value_a  out  WIDTH  to adder Value_a, registered.
- add_value_b  out  WIDTH  to adder Value_b, registered.
- add_data_val  out  1  to adder Data_val, registered.
- add_sum_result  in  WIDTH  from adder Sum_result.
- add_sum_carry  in  1  from adder Sum_carry.
- add_data_ready  in  1  from adder Data_ready.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_id  out  clog2(NUM_REQ)  requester that owns the result.
- rsp_sum  out  WIDTH  registered sum.
- rsp_carry  out  1  registered carry.
- busy  out  1  1 while any operation is issued but not yet responded.
- seq_err  out  1  sticky completion-mismatch flag.
- op_count  out  CNT_W  completed responses; wraps.

Behaviour:
- Reset (reset_n low at posedge):
  - add_value_a/b=0, add_data_val=0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0.
  - seq_err=0, op_count=0.
  - RR pointer=0; tag pipeline cleared; busy=0.
  - req_ready is forced to 0 while reset_n is low.
- Arbitration (combinational):
  - If arb_en=1, grant the first i with req_valid[i]=1, searching from the pointer upward modulo NUM_REQ.
  - req_ready = grant one-hot; with no valid requests, req_ready=0.
  - Throughput: one accept per cycle.
  - req_ready never depends on rsp or the adder, because the adder is fully pipelined.
- On accept of requester g at edge T:
  - add_value_a/b <= req_a/req_b slice g; add_data_val <= 1.
  - pointer <= (g+1) mod NUM_REQ.
  - Push {1, g} into the tag pipeline.
- Cycles with no accept: add_data_val <= 0; add_value_a/b hold their previous value; pointer holds.
- Tag pipeline:
  - ADDER_LAT stages of {valid, id}, advancing every cycle, aligned with add_data_val.
  - Stage ADDER_LAT-1's output lines up with add_data_ready.
- Completion:
  - If add_data_ready=1 and the aligned tag valid=1: next edge rsp_valid<=1, rsp_id<=tag id, rsp_sum<=add_sum_result, rsp_carry<=add_sum_carry, op_count<=op_count+1 (wraps at 2^CNT_W).
  - Otherwise rsp_valid<=0; rsp_sum/rsp_carry/rsp_id hold.
- Latency: accept at edge T → add_data_val high T..T+1 → add_data_ready high after T+2 → rsp_valid high after edge T+3. Fixed 3 cycles; back-to-back accepts produce back-to-back responses in accept order.
- seq_err: set when add_data_ready ≠ aligned tag valid; cleared only by reset.
- busy: OR of add_data_val, all tag-stage valid bits, and the pending response.
- arb_en deasserted mid-stream: no new grants from the next combinational evaluation; in-flight ops complete normally; pointer holds.
- Simultaneous requests from all requesters: served strictly in pointer order, i.e. each requester at most once per NUM_REQ grants.
- Request withdrawn (req_valid drops without ready): legal; no transfer and no pointer change.
- Reset mid-operation: all in-flight tags are discarded and no rsp is produced for them.
  - The adder shares reset_n, so its pipeline is also cleared.
  - Requesters must reissue.
- Arithmetic: no arbiter-side arithmetic; sum and carry are passed through from the adder's {carry, WIDTH-bit sum}.

Test Plan:
- Single op: reset, arb_en=1, req 2 only with a=0x3C, b=0x55 → req_ready=0b0100 in that cycle; add_data_val high next cycle; rsp_valid exactly 3 cycles after accept with rsp_id=2, sum=0x91, carry=0; op_count=1.
- Overflow: req 0 with a=0xFF, b=0x01 → rsp sum=0x00, carry=1; a=0x80, b=0x80 → sum=0x00, carry=1.
- Fairness: all 4 req_valid held high for 8 cycles with distinct operands → grant order 0,1,2,3,0,1,2,3; rsp_id sequence identical and back-to-back; op_count=8.
- Pointer continuity: grant req 1, then only req 0 and 3 valid → next grant is 3, then 0.
- Drain/enable: 3 ops in flight, drop arb_en → req_ready=0; all 3 responses still arrive; busy falls 1 cycle after the last rsp_valid.
- Error and reset: force add_data_ready=1 with an empty pipeline → seq_err=1 and sticky, with no rsp_valid. Reset with 2 ops in flight → no rsp appears, and all outputs return to reset values.
